// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider. Each channel emits a divided clock level
// and a one-cycle enable on its rising edge; divisor/phase changes apply at period end.
module clock_div_multi #(
    parameter  int NCH     = 4,
    parameter  int CW      = 8,
    parameter  int DEF_DIV = 16,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clkin,
    input  logic           RST,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic [CW-1:0]  cfg_phase,
    input  logic           sync,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] clk_en,
    output logic [NCH-1:0] pending
);

    localparam logic [CHW:0]  NCH_L = (CHW+1)'(NCH);
    localparam logic [CW-1:0] DEF_L = CW'(DEF_DIV);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] TWO   = CW'(2);

    // High portion of the period: ceil(d/2) cycles.
    function automatic logic [CW-1:0] hi_time(input logic [CW-1:0] d);
        return d - (d >> 1);
    endfunction

    logic          ch_valid;
    logic          cfg_accept;
    logic [CW-1:0] phase_fixed;

    assign ch_valid = ({1'b0, cfg_ch} < NCH_L);

    always_comb begin
        cfg_ready = 1'b1;
        if (ch_valid)
            cfg_ready = ~pending[cfg_ch];
    end

    assign cfg_accept  = cfg_valid & cfg_ready & ch_valid;
    // A phase outside the period would leave the counter past its wrap point.
    assign phase_fixed = ((cfg_div != '0) && (cfg_phase >= cfg_div)) ? '0 : cfg_phase;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] div_q, phase_q, cnt_q, sh_div_q, sh_phase_q;
        logic          pend_q, out_q, en_q;
        logic          acc;
        logic          at_end;

        assign acc    = cfg_accept && (cfg_ch == CHW'(i));
        assign at_end = (cnt_q == div_q - ONE);

        always_ff @(posedge clkin) begin
            if (RST) begin
                div_q      <= DEF_L;
                phase_q    <= '0;
                cnt_q      <= '0;
                sh_div_q   <= DEF_L;
                sh_phase_q <= '0;
                pend_q     <= 1'b0;
                out_q      <= 1'b0;
                en_q       <= 1'b0;
            end else begin
                if (div_q >= TWO) begin
                    out_q <= (cnt_q < hi_time(div_q));
                    en_q  <= (cnt_q == '0);
                    if (sync)
                        cnt_q <= phase_q;
                    else
                        cnt_q <= at_end ? '0 : cnt_q + ONE;
                end else begin
                    out_q <= (div_q == ONE);
                    en_q  <= (div_q == ONE);
                    cnt_q <= '0;
                end
                // Swap in the shadow only at a period boundary so no runt pulse appears.
                if (pend_q && ((div_q <= ONE) || at_end)) begin
                    div_q   <= sh_div_q;
                    phase_q <= sh_phase_q;
                    cnt_q   <= sh_phase_q;
                    pend_q  <= 1'b0;
                end
                if (acc) begin
                    sh_div_q   <= cfg_div;
                    sh_phase_q <= phase_fixed;
                    pend_q     <= 1'b1;
                end
            end
        end

        assign clk_out[i] = out_q;
        assign clk_en[i]  = en_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Randomized scoreboard bench for clock_div_multi against a period/position reference model.
module tb_clock_div_multi;

    localparam int NCH = 5;
    localparam int CW = 8;
    localparam int DEF_DIV = 16;
    localparam int CHW = 3;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic           RST = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic [CW-1:0]  cfg_phase = '0;
    logic           sync = 1'b0;
    logic [NCH-1:0] clk_out, clk_en, pending;

    clock_div_multi #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV)) dut (
        .clkin(clkin), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .sync(sync),
        .clk_out(clk_out), .clk_en(clk_en), .pending(pending)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NCH-1:0] o;
        logic [NCH-1:0] e;
        logic [NCH-1:0] p;
    } exp_t;
    exp_t expq[$];

    // Reference state: divisor, phase, position within period, shadow, pending.
    int md[NCH], mp[NCH], mpos[NCH], msd[NCH], msp[NCH];
    bit mpend[NCH];

    function automatic bit exp_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return !mpend[int'(cfg_ch)];
    endfunction

    always @(posedge clkin) begin
        exp_t x;
        int   ch;
        bit   acc;
        bit   ap;
        ch  = int'(cfg_ch);
        acc = cfg_valid && (ch < NCH) && !mpend[ch];
        x   = '0;
        if (RST) begin
            for (int i = 0; i < NCH; i++) begin
                md[i] = DEF_DIV; mp[i] = 0; mpos[i] = 0;
                msd[i] = DEF_DIV; msp[i] = 0; mpend[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (md[i] >= 2) begin
                    x.o[i] = (mpos[i] < (md[i] + 1) / 2);
                    x.e[i] = (mpos[i] == 0);
                end else begin
                    x.o[i] = (md[i] == 1);
                    x.e[i] = (md[i] == 1);
                end
                ap = mpend[i] && (md[i] <= 1 || mpos[i] == md[i] - 1);
                if (ap) begin
                    md[i] = msd[i]; mp[i] = msp[i]; mpos[i] = msp[i]; mpend[i] = 0;
                end else if (md[i] >= 2) begin
                    mpos[i] = sync ? mp[i] : (mpos[i] + 1) % md[i];
                end else begin
                    mpos[i] = 0;
                end
                if (acc && ch == i) begin
                    msd[i] = int'(cfg_div);
                    msp[i] = (cfg_div != 0 && cfg_phase >= cfg_div) ? 0 : int'(cfg_phase);
                    mpend[i] = 1;
                end
                x.p[i] = mpend[i];
            end
        end
        expq.push_back(x);
    end

    always @(negedge clkin) begin
        exp_t x;
        if (expq.size() > 0) begin
            x = expq.pop_front();
            checks += 3;
            if (clk_out !== x.o) begin
                errors++;
                $display("FAIL clk_out t=%0t got %b want %b", $time, clk_out, x.o);
            end
            if (clk_en !== x.e) begin
                errors++;
                $display("FAIL clk_en t=%0t got %b want %b", $time, clk_en, x.e);
            end
            if (pending !== x.p) begin
                errors++;
                $display("FAIL pending t=%0t got %b want %b", $time, pending, x.p);
            end
        end
    end

    task automatic cyc(input bit rst, input bit v, input int ch, input int dv,
                       input int ph, input bit sy);
        @(negedge clkin);
        RST = rst; cfg_valid = v; cfg_ch = CHW'(ch);
        cfg_div = CW'(dv); cfg_phase = CW'(ph); sync = sy;
        #1;
        checks++;
        if (cfg_ready !== exp_ready()) begin
            errors++;
            $display("FAIL cfg_ready ch=%0d got %b want %b", ch, cfg_ready, exp_ready());
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 0, 0);
        idle(37);
        cyc(0, 1, 1, 5, 0, 0);          // ch1 div=5 mid-period
        idle(40);
        cyc(0, 1, 2, 0, 0, 0);          // ch2 stop
        idle(20);
        cyc(0, 1, 2, 1, 0, 0);          // ch2 div=1
        idle(10);
        cyc(0, 1, 0, 8, 0, 0);
        cyc(0, 1, 3, 8, 4, 0);
        idle(40);
        cyc(0, 0, 0, 0, 0, 1);          // sync pulse
        idle(30);
        cyc(0, 1, 4, 6, 9, 0);          // phase >= div folds to 0
        idle(20);
        cyc(0, 1, 5, 3, 0, 0);          // out-of-range channel
        idle(5);
        cyc(0, 1, 1, 7, 2, 0);
        cyc(1, 0, 0, 0, 0, 0);          // reset drops the pending shadow
        idle(40);
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom % 1000) < 3, ($urandom % 10) < 3, int'($urandom % 8),
                int'($urandom % 13), int'($urandom % 16), ($urandom % 100) < 3);
        end
        idle(20);
        @(negedge clkin);
        #2;
        checks++;
        if (expq.size() > 1) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want <=1", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
